// File: rtl/zeta_mask_gen_pkg.sv
// Shared NTT definitions: mode codes, transform geometry, LFSR constants and
// the mask-generator FSM state type.
package ntt_pkg;

  localparam logic [2:0] FORWARD_NTT_MODE = 3'd0;
  localparam logic [2:0] INVERSE_NTT_MODE = 3'd1;

  localparam int unsigned N2      = 512;
  localparam int unsigned ZW      = $clog2(N2);
  localparam int unsigned BEATS   = 64;
  localparam int unsigned ROUNDS  = 4;
  localparam int unsigned NUM_NEW = 5;
  localparam int unsigned NUM_OLD = 4;

  localparam int unsigned        LFSR_W    = 32;
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 32'h8020_0003;

  localparam int unsigned BEAT_W  = $clog2(BEATS);
  localparam int unsigned ROUND_W = $clog2(ROUNDS);
  localparam int unsigned DRAW_W  = $clog2(NUM_NEW);

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);
  localparam logic [DRAW_W-1:0]  LAST_DRAW  = DRAW_W'(NUM_NEW - 1);

  typedef logic [ZW-1:0] zeta_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    RUN,
    FIN
  } state_e;

endpackage

// File: rtl/zeta_mask_gen_if.sv
// Control and mask bus between the transform controller (master) and the
// mask generator (slave).
interface zeta_mask_gen_if;
  import ntt_pkg::*;

  logic [2:0]        mode;
  logic              start;
  logic [LFSR_W-1:0] seed;
  logic              en;

  zeta_t zeta_new_1, zeta_new_2, zeta_new_3, zeta_new_4, zeta_new_5;
  zeta_t zeta0_old_1, zeta1_old_2, zeta2_old_3, zeta3_old_4;
  logic  zeta_valid;
  logic  busy;
  logic  done;

  modport master (
    output mode, start, seed, en,
    input  zeta_new_1, zeta_new_2, zeta_new_3, zeta_new_4, zeta_new_5,
    input  zeta0_old_1, zeta1_old_2, zeta2_old_3, zeta3_old_4,
    input  zeta_valid, busy, done
  );

  modport slave (
    input  mode, start, seed, en,
    output zeta_new_1, zeta_new_2, zeta_new_3, zeta_new_4, zeta_new_5,
    output zeta0_old_1, zeta1_old_2, zeta2_old_3, zeta3_old_4,
    output zeta_valid, busy, done
  );

endinterface

// File: rtl/zeta_mask_gen_lfsr9_step.sv
// Combinational 9-step advance of a right-shifting Galois LFSR; shared by the
// masking blocks that need one 9-bit draw per cycle.
module lfsr9_step
  import ntt_pkg::*;
#(
  parameter int unsigned   W    = LFSR_W,
  parameter logic [W-1:0]  TAPS = LFSR_TAPS
) (
  input  logic [W-1:0] state_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] s;

  always_comb begin
    s = state_i;
    for (int unsigned i = 0; i < 9; i++) begin
      s = (s >> 1) ^ (s[0] ? TAPS : '0);
    end
    state_o = s;
  end

endmodule

// File: rtl/zeta_mask_gen.sv
// Per-round twiddle-offset mask generator for the NTT/INTT address resolver.
// Build with ZETA_MASK_EN defined for LFSR masks; otherwise all masks are 0.
module zeta_mask_gen
  import ntt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  zeta_mask_gen_if.slave  zm
);

  state_e               state_q, state_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [DRAW_W-1:0]    draw_idx_q, draw_idx_d;
  logic [2:0]           mode_q, mode_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

`ifdef ZETA_MASK_EN
  logic [LFSR_W-1:0]         lfsr_q, lfsr_d, lfsr_nxt;
  zeta_t [NUM_NEW-1:0]       new_q, new_d;
  zeta_t [NUM_OLD-1:0]       old_q, old_d;

  lfsr9_step #(.W(LFSR_W), .TAPS(LFSR_TAPS)) u_step (
    .state_i (lfsr_q),
    .state_o (lfsr_nxt)
  );
`endif

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    beat_d     = beat_q;
    draw_idx_d = draw_idx_q;
    mode_d     = mode_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef ZETA_MASK_EN
    lfsr_d     = lfsr_q;
    new_d      = new_q;
    old_d      = old_q;
`endif
    case (state_q)
      IDLE: begin
        if (zm.start && (zm.mode == FORWARD_NTT_MODE || zm.mode == INVERSE_NTT_MODE)) begin
          state_d    = DRAW;
          mode_d     = zm.mode;
          round_d    = '0;
          beat_d     = '0;
          draw_idx_d = '0;
          busy_d     = 1'b1;
`ifdef ZETA_MASK_EN
          lfsr_d     = (zm.seed == '0) ? LFSR_W'(1) : zm.seed;
          old_d      = '0;
`endif
        end
      end
      DRAW: begin
`ifdef ZETA_MASK_EN
        lfsr_d = lfsr_nxt;
        for (int unsigned i = 0; i < NUM_NEW; i++) begin
          if (draw_idx_q == DRAW_W'(i)) new_d[i] = lfsr_nxt[ZW-1:0];
        end
`endif
        if (draw_idx_q == LAST_DRAW) begin
          state_d    = RUN;
          beat_d     = '0;
          draw_idx_d = '0;
          valid_d    = 1'b1;
        end else begin
          draw_idx_d = draw_idx_q + 1'b1;
        end
      end
      RUN: begin
        if (zm.en) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            valid_d = 1'b0;
            if (round_q == LAST_ROUND) begin
              state_d = FIN;
              done_d  = 1'b1;
            end else begin
              state_d = DRAW;
              round_d = round_q + 1'b1;
`ifdef ZETA_MASK_EN
              // new_5 is deliberately dropped: the resolver only cancels four
              old_d = new_q[NUM_OLD-1:0];
`endif
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      round_q    <= '0;
      beat_q     <= '0;
      draw_idx_q <= '0;
      mode_q     <= FORWARD_NTT_MODE;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ZETA_MASK_EN
      lfsr_q     <= LFSR_W'(1);
      new_q      <= '0;
      old_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      beat_q     <= beat_d;
      draw_idx_q <= draw_idx_d;
      mode_q     <= mode_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ZETA_MASK_EN
      lfsr_q     <= lfsr_d;
      new_q      <= new_d;
      old_q      <= old_d;
`endif
    end
  end

  // Only legal transform modes may ever be latched while a transform runs.
  a_mode_legal: assert property (@(posedge clk) disable iff (rst)
    busy_q |-> (mode_q == FORWARD_NTT_MODE || mode_q == INVERSE_NTT_MODE));

`ifdef ZETA_MASK_EN
  assign zm.zeta_new_1  = new_q[0];
  assign zm.zeta_new_2  = new_q[1];
  assign zm.zeta_new_3  = new_q[2];
  assign zm.zeta_new_4  = new_q[3];
  assign zm.zeta_new_5  = new_q[4];
  assign zm.zeta0_old_1 = old_q[0];
  assign zm.zeta1_old_2 = old_q[1];
  assign zm.zeta2_old_3 = old_q[2];
  assign zm.zeta3_old_4 = old_q[3];
`else
  assign zm.zeta_new_1  = '0;
  assign zm.zeta_new_2  = '0;
  assign zm.zeta_new_3  = '0;
  assign zm.zeta_new_4  = '0;
  assign zm.zeta_new_5  = '0;
  assign zm.zeta0_old_1 = '0;
  assign zm.zeta1_old_2 = '0;
  assign zm.zeta2_old_3 = '0;
  assign zm.zeta3_old_4 = '0;
`endif

  assign zm.zeta_valid = valid_q;
  assign zm.busy       = busy_q;
  assign zm.done       = done_q;

endmodule

// File: tb/tb_zeta_mask_gen.sv
// Scoreboard bench for zeta_mask_gen: per-round expected masks are queued at
// start and checked when zeta_valid rises; round length and stability tracked.
module tb_zeta_mask_gen;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic rst;

  zeta_mask_gen_if zm();

  zeta_mask_gen dut (
    .clk (clk),
    .rst (rst),
    .zm  (zm.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0][8:0] nw;
    logic [3:0][8:0] od;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  bit   prev_valid = 1'b0;
  int   beats      = 0;
  int   unstable   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [44:0] get_new();
    return {zm.zeta_new_5, zm.zeta_new_4, zm.zeta_new_3, zm.zeta_new_2, zm.zeta_new_1};
  endfunction

  function automatic logic [35:0] get_old();
    return {zm.zeta3_old_4, zm.zeta2_old_3, zm.zeta1_old_2, zm.zeta0_old_1};
  endfunction

  function automatic logic [31:0] model_step9(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 9; i++) begin
      if (r[0]) r = (r >> 1) ^ 32'h8020_0003;
      else      r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_transform(input logic [31:0] seed);
    logic [31:0] s;
    exp_t        e;
    s    = (seed == 32'd0) ? 32'd1 : seed;
    e.od = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++) begin
        s = model_step9(s);
`ifdef ZETA_MASK_EN
        e.nw[k] = s[8:0];
`else
        e.nw[k] = 9'd0;
`endif
      end
      sb_q.push_back(e);
      for (int j = 0; j < 4; j++) e.od[j] = e.nw[j];
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      beats      = 0;
      unstable   = 0;
    end else begin
      if (zm.zeta_valid && !prev_valid) begin
        check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          cur = sb_q.pop_front();
          check_eq("zeta_new", 64'(get_new()), 64'(cur.nw));
          check_eq("zeta_old", 64'(get_old()), 64'(cur.od));
        end
        beats    = 0;
        unstable = 0;
      end else if (zm.zeta_valid) begin
        if (get_new() !== cur.nw || get_old() !== cur.od) unstable++;
      end else if (prev_valid) begin
        check_eq("round_beats", 64'(beats), 64'd64);
        check_eq("mask_stable", 64'(unstable), 64'd0);
      end
      if (zm.zeta_valid && zm.en) beats++;
      prev_valid = zm.zeta_valid;
    end
  end

  task automatic run_xform(input logic [31:0] seed, input logic [2:0] mode,
                           input bit rnd_en, input int glitch_at, input int rst_at);
    int first_valid;
    int done_n;
    first_valid = -1;
    done_n      = -1;
    push_transform(seed);
    zm.seed  = seed;
    zm.mode  = mode;
    zm.start = 1'b1;
    zm.en    = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      zm.start = (n == glitch_at);
      if (n == glitch_at) begin
        zm.seed = ~seed;
        zm.mode = INVERSE_NTT_MODE;
      end
      if (n == 1) check_eq("busy_after_start", 64'(zm.busy), 64'd1);
      if (zm.zeta_valid && first_valid < 0) first_valid = n;
      if (rst_at != 0 && n == rst_at + 1) begin
        check_eq("rst_mid_new", 64'(get_new()), 64'd0);
        check_eq("rst_mid_old", 64'(get_old()), 64'd0);
        check_eq("rst_mid_flags", 64'({zm.zeta_valid, zm.busy, zm.done}), 64'd0);
        rst = 1'b0;
        sb_q.delete();
        break;
      end
      if (rst_at != 0 && n == rst_at) begin
        check_eq("pre_rst_valid", 64'(zm.zeta_valid), 64'd1);
        rst = 1'b1;
      end
      if (zm.done) begin
        done_n = n;
        break;
      end
      if (rnd_en) zm.en = 1'($urandom_range(0, 1));
    end
    zm.en = 1'b0;
    check_eq("first_valid_cycle", 64'(first_valid), 64'd6);
    if (rst_at == 0) begin
      if (rnd_en) check_eq("done_seen", 64'(done_n > 0), 64'd1);
      else        check_eq("done_cycle", 64'(done_n), 64'd277);
      @(posedge clk); #1;
      check_eq("done_pulse_idle", 64'({zm.done, zm.busy, zm.zeta_valid}), 64'd0);
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    zm.start = 1'b0;
    zm.mode  = FORWARD_NTT_MODE;
    zm.seed  = 32'd0;
    zm.en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_new", 64'(get_new()), 64'd0);
    check_eq("rst_old", 64'(get_old()), 64'd0);
    check_eq("rst_flags", 64'({zm.zeta_valid, zm.busy, zm.done}), 64'd0);
    rst = 1'b0;

    // Illegal modes are ignored
    for (int m = 2; m < 8; m += 5) begin
      zm.mode  = 3'(m);
      zm.start = 1'b1;
      zm.en    = 1'b1;
      @(posedge clk); #1;
      zm.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("bad_mode_busy", 64'({zm.busy, zm.zeta_valid}), 64'd0);
    end
    zm.en = 1'b0;

    run_xform(32'h0000_0001, FORWARD_NTT_MODE, 1'b0, 100, 0);
    run_xform(32'h0000_0000, FORWARD_NTT_MODE, 1'b1, 0, 0);
    run_xform(32'hDEAD_BEEF, INVERSE_NTT_MODE, 1'b0, 0, 174);

    repeat (2) @(posedge clk);
    #1;
    check_eq("post_rst_idle", 64'({zm.busy, zm.zeta_valid, zm.done}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
